// File: rtl/cnn_pkg.sv
// Shared constants and helpers for the CNN convolution line-buffer blocks.
// Holds default widths, counter-width derivation and window element indexing.
package cnn_pkg;

    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_WIDTH     = 28;
    localparam int DEFAULT_HEIGHT    = 28;

    // Counter width for a range 0..n-1; never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_X_BITS = cnt_bits(DEFAULT_WIDTH);
    localparam int DEFAULT_Y_BITS = cnt_bits(DEFAULT_HEIGHT);

    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/conv_line_fifo.sv
// Single-clock delay line: dout is the sample accepted DEPTH shifts earlier.
// Shifts only on shift_en so input gaps do not disturb row alignment.
module conv_line_fifo
    import cnn_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_WIDTH,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_buf.sv
// Sliding KxK window line buffer with stride; optional sof/eol border flags
// are built when CONV_WINDOW_BUF_BORDER_EN is defined.
module conv_window_buf
    import cnn_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int HEIGHT    = DEFAULT_HEIGHT,
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int K         = 5,
    parameter int STRIDE    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic [DATA_BITS-1:0]         data_in,
    output logic [K*K*DATA_BITS-1:0]     window_out,
    output logic                         valid_out,
    output logic [$clog2(WIDTH)-1:0]     out_x,
    output logic [$clog2(HEIGHT)-1:0]    out_y,
    output logic                         frame_done
`ifdef CONV_WINDOW_BUF_BORDER_EN
    ,
    output logic                         sof,
    output logic                         eol
`endif
);

    // valid_in qualifies data_in for one cycle; there is no ready, so every
    // valid_out pulse must be consumed in the cycle it appears.
    localparam int XW = cnt_bits(WIDTH);
    localparam int YW = cnt_bits(HEIGHT);
    localparam int PW = cnt_bits(STRIDE);
    localparam int NX = (WIDTH - K) / STRIDE + 1;
    localparam int NY = (HEIGHT - K) / STRIDE + 1;

    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [XW-1:0] X_EMIT  = XW'(K - 1 + (NX - 1) * STRIDE);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_EMIT  = YW'(K - 1 + (NY - 1) * STRIDE);
    localparam logic [PW-1:0] P_LAST  = PW'(STRIDE - 1);

    logic [DATA_BITS-1:0] tap [K-1];
    logic [DATA_BITS-1:0] col [K];
    logic [DATA_BITS-1:0] win [K][K];
    logic [XW-1:0]        in_x, ox_cnt;
    logic [YW-1:0]        in_y, oy_cnt;
    logic [PW-1:0]        ph_x, ph_y;
    logic                 emit;

    for (genvar i = 0; i < K - 1; i++) begin : g_fifo
        if (i == 0) begin : g_head
            conv_line_fifo #(.DEPTH(WIDTH), .DATA_BITS(DATA_BITS)) u_fifo (
                .clk(clk), .rst(rst), .shift_en(valid_in), .din(data_in), .dout(tap[i])
            );
        end else begin : g_tail
            conv_line_fifo #(.DEPTH(WIDTH), .DATA_BITS(DATA_BITS)) u_fifo (
                .clk(clk), .rst(rst), .shift_en(valid_in), .din(tap[i-1]), .dout(tap[i])
            );
        end
    end

    // Deepest FIFO tap feeds the oldest window row.
    always_comb begin
        for (int r = 0; r < K - 1; r++) col[r] = tap[K-2-r];
        col[K-1] = data_in;
    end

    always_comb begin
        window_out = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                window_out[win_idx(r, c, K)*DATA_BITS +: DATA_BITS] = win[r][c];
    end

    assign emit = valid_in && (in_x >= X_FIRST) && (in_y >= Y_FIRST)
                  && (ph_x == '0) && (ph_y == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++) win[r][c] <= '0;
            in_x       <= '0;
            in_y       <= '0;
            ox_cnt     <= '0;
            oy_cnt     <= '0;
            ph_x       <= '0;
            ph_y       <= '0;
            valid_out  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
`ifdef CONV_WINDOW_BUF_BORDER_EN
            sof        <= 1'b0;
            eol        <= 1'b0;
`endif
        end else begin
            valid_out  <= emit;
            frame_done <= emit && (in_x == X_EMIT) && (in_y == Y_EMIT);
`ifdef CONV_WINDOW_BUF_BORDER_EN
            sof        <= emit && (ox_cnt == '0) && (oy_cnt == '0);
            eol        <= emit && (in_x == X_EMIT);
`endif
            if (emit) begin
                out_x <= ox_cnt;
                out_y <= oy_cnt;
            end
            if (valid_in) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
                    win[r][K-1] <= col[r];
                end
                // Phases are forced to 0 just before the first emit column/row.
                if (in_x == X_LAST) begin
                    in_x   <= '0;
                    ph_x   <= '0;
                    ox_cnt <= '0;
                    if (in_y == Y_LAST) begin
                        in_y   <= '0;
                        ph_y   <= '0;
                        oy_cnt <= '0;
                    end else begin
                        in_y <= in_y + YW'(1);
                        if (in_y < Y_FIRST) ph_y <= '0;
                        else ph_y <= (ph_y == P_LAST) ? '0 : ph_y + PW'(1);
                        if (in_y >= Y_FIRST && ph_y == '0) oy_cnt <= oy_cnt + YW'(1);
                    end
                end else begin
                    in_x <= in_x + XW'(1);
                    if (in_x < X_FIRST) ph_x <= '0;
                    else ph_x <= (ph_x == P_LAST) ? '0 : ph_x + PW'(1);
                    if (emit) ox_cnt <= ox_cnt + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buf.sv
// Directed bench for conv_window_buf: three configurations (28/5/1, 28/5/2, 8/3/3)
// fed raster ramps; sof/eol are checked when CONV_WINDOW_BUF_BORDER_EN is defined.
module tb_conv_window_buf;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       vin;
    logic [7:0] din;
    logic [1:0] sel;
    logic       va, vb, vc;
    assign va = vin && (sel == 2'd0);
    assign vb = vin && (sel == 2'd1);
    assign vc = vin && (sel == 2'd2);

    logic [199:0] wa, wb;
    logic [71:0]  wc;
    logic         vouta, voutb, voutc, fda, fdb, fdc;
    logic [4:0]   xa, ya, xb, yb;
    logic [2:0]   xc, yc;
    logic         sofa, sofb, sofc, eola, eolb, eolc;

    conv_window_buf #(.WIDTH(28), .HEIGHT(28), .DATA_BITS(8), .K(5), .STRIDE(1)) u_dut_a (
        .clk(clk), .rst(rst), .valid_in(va), .data_in(din), .window_out(wa),
        .valid_out(vouta), .out_x(xa), .out_y(ya), .frame_done(fda)
`ifdef CONV_WINDOW_BUF_BORDER_EN
        , .sof(sofa), .eol(eola)
`endif
    );

    conv_window_buf #(.WIDTH(28), .HEIGHT(28), .DATA_BITS(8), .K(5), .STRIDE(2)) u_dut_b (
        .clk(clk), .rst(rst), .valid_in(vb), .data_in(din), .window_out(wb),
        .valid_out(voutb), .out_x(xb), .out_y(yb), .frame_done(fdb)
`ifdef CONV_WINDOW_BUF_BORDER_EN
        , .sof(sofb), .eol(eolb)
`endif
    );

    conv_window_buf #(.WIDTH(8), .HEIGHT(8), .DATA_BITS(8), .K(3), .STRIDE(3)) u_dut_c (
        .clk(clk), .rst(rst), .valid_in(vc), .data_in(din), .window_out(wc),
        .valid_out(voutc), .out_x(xc), .out_y(yc), .frame_done(fdc)
`ifdef CONV_WINDOW_BUF_BORDER_EN
        , .sof(sofc), .eol(eolc)
`endif
    );

`ifndef CONV_WINDOW_BUF_BORDER_EN
    assign {sofa, sofb, sofc, eola, eolb, eolc} = '0;
`endif

    logic [199:0] obs_win;
    logic [4:0]   obs_x, obs_y;
    logic         obs_v, obs_fd, obs_sof, obs_eol;

    always_comb begin
        obs_win = wa; obs_v = vouta; obs_x = xa; obs_y = ya; obs_fd = fda;
        obs_sof = sofa; obs_eol = eola;
        if (sel == 2'd1) begin
            obs_win = wb; obs_v = voutb; obs_x = xb; obs_y = yb; obs_fd = fdb;
            obs_sof = sofb; obs_eol = eolb;
        end else if (sel == 2'd2) begin
            obs_win = {128'b0, wc}; obs_v = voutc; obs_x = {2'b0, xc}; obs_y = {2'b0, yc};
            obs_fd = fdc; obs_sof = sofc; obs_eol = eolc;
        end
    end

    int checks = 0;
    int failures = 0;
    int cw, ch, ck, cs, nx, ny;
    int mx, my, win_cnt, fd_cnt;
    logic [15:0] exp_q[$];

    task automatic set_cfg(input logic [1:0] s, input int w, input int k, input int st);
        sel = s; cw = w; ch = w; ck = k; cs = st;
        nx = (w - k) / st + 1;
        ny = (w - k) / st + 1;
        mx = 0; my = 0; win_cnt = 0; fd_cnt = 0;
        exp_q.delete();
    endtask

    // Driver plus scoreboard: pushes expected window indices, checks each cycle.
    task automatic drive_and_score(input int npix, input int duty);
        int sent = 0;
        int cycles = 0;
        bit pend = 0;
        int k, ex_ox, ex_oy;
        logic [199:0] exp_win;
        while (sent < npix && cycles < npix * 8 + 50) begin
            if ($urandom_range(99) < duty) begin
                vin = 1'b1;
                din = 8'((my * cw + mx) & 255);
                pend = (mx >= ck - 1) && (my >= ck - 1)
                       && ((mx - (ck - 1)) % cs == 0) && ((my - (ck - 1)) % cs == 0);
                if (pend) exp_q.push_back(16'(((my - (ck - 1)) / cs) * nx + (mx - (ck - 1)) / cs));
                sent++;
                mx++;
                if (mx == cw) begin
                    mx = 0; my++;
                    if (my == ch) my = 0;
                end
            end else begin
                vin = 1'b0;
                pend = 0;
            end
            @(negedge clk);
            cycles++;
            checks++;
            if (obs_v !== pend) begin
                failures++;
                $display("FAIL valid_out: got %b expected %b (cycle %0d)", obs_v, pend, cycles);
            end
            if (obs_v === 1'b1) begin
                win_cnt++;
                if (obs_fd === 1'b1) fd_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL window_order: got a window with none expected");
                end else begin
                    k = int'(exp_q.pop_front());
                    ex_ox = k % nx;
                    ex_oy = k / nx;
                    exp_win = '0;
                    for (int r = 0; r < ck; r++)
                        for (int c = 0; c < ck; c++)
                            exp_win[(r * ck + c) * 8 +: 8] = 8'(((ex_oy * cs + r) * cw + ex_ox * cs + c) & 255);
                    if (obs_x !== 5'(ex_ox) || obs_y !== 5'(ex_oy)) begin
                        failures++;
                        $display("FAIL out_xy: got (%0d,%0d) expected (%0d,%0d)", obs_x, obs_y, ex_ox, ex_oy);
                    end
                    checks++;
                    if (obs_win !== exp_win) begin
                        failures++;
                        $display("FAIL window_out: got %h expected %h", obs_win, exp_win);
                    end
                    checks++;
                    if (obs_fd !== (k == nx * ny - 1)) begin
                        failures++;
                        $display("FAIL frame_done: got %b expected %b at window %0d", obs_fd, (k == nx * ny - 1), k);
                    end
`ifdef CONV_WINDOW_BUF_BORDER_EN
                    checks++;
                    if (obs_sof !== (k == 0) || obs_eol !== (ex_ox == nx - 1)) begin
                        failures++;
                        $display("FAIL sof_eol: got %b%b expected %b%b at window %0d",
                                 obs_sof, obs_eol, (k == 0), (ex_ox == nx - 1), k);
                    end
`endif
                end
            end else begin
                checks++;
                if (obs_fd !== 1'b0 || obs_sof !== 1'b0 || obs_eol !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_flags: got fd=%b sof=%b eol=%b expected 000", obs_fd, obs_sof, obs_eol);
                end
            end
        end
        vin = 1'b0;
        checks++;
        if (sent != npix) begin
            failures++;
            $display("FAIL cycle_budget: got %0d pixels sent expected %0d", sent, npix);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; vin = 1'b0; din = '0; sel = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (wa !== '0 || vouta !== 1'b0 || xa !== '0 || ya !== '0 || fda !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: got win=%h v=%b x=%0d y=%0d fd=%b expected all 0", wa, vouta, xa, ya, fda);
        end
        checks++;
        if (wc !== '0 || voutc !== 1'b0 || xc !== '0 || yc !== '0 || fdc !== 1'b0) begin
            failures++;
            $display("FAIL reset_c: got win=%h v=%b x=%0d y=%0d fd=%b expected all 0", wc, voutc, xc, yc, fdc);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp_stride1;
        set_cfg(2'd0, 28, 5, 1);
        drive_and_score(784, 100);
        checks++;
        if (win_cnt != 576 || fd_cnt != 1) begin
            failures++;
            $display("FAIL ramp_s1_count: got %0d windows %0d done expected 576 1", win_cnt, fd_cnt);
        end
        checks++;
        if (xa !== 5'd23 || ya !== 5'd23) begin
            failures++;
            $display("FAIL ramp_s1_last: got (%0d,%0d) expected (23,23)", xa, ya);
        end
    endtask

    task automatic test_ramp_stride2;
        set_cfg(2'd1, 28, 5, 2);
        drive_and_score(784, 100);
        checks++;
        if (win_cnt != 144 || fd_cnt != 1) begin
            failures++;
            $display("FAIL ramp_s2_count: got %0d windows %0d done expected 144 1", win_cnt, fd_cnt);
        end
        checks++;
        if (xb !== 5'd11 || yb !== 5'd11) begin
            failures++;
            $display("FAIL ramp_s2_last: got (%0d,%0d) expected (11,11)", xb, yb);
        end
    endtask

    task automatic test_random_valid;
        logic [199:0] held;
        set_cfg(2'd0, 28, 5, 1);
        drive_and_score(784, 50);
        checks++;
        if (win_cnt != 576 || fd_cnt != 1) begin
            failures++;
            $display("FAIL random_count: got %0d windows %0d done expected 576 1", win_cnt, fd_cnt);
        end
        held = wa;
        repeat (3) @(negedge clk);
        checks++;
        if (wa !== held || vouta !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: got v=%b win=%h expected v=0 win=%h", vouta, wa, held);
        end
    endtask

    task automatic test_back_to_back;
        set_cfg(2'd0, 28, 5, 1);
        drive_and_score(1568, 100);
        checks++;
        if (win_cnt != 1152 || fd_cnt != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d windows %0d done expected 1152 2", win_cnt, fd_cnt);
        end
    endtask

    task automatic test_reset_mid_frame;
        set_cfg(2'd0, 28, 5, 1);
        drive_and_score(300, 100);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wa !== '0 || vouta !== 1'b0 || xa !== '0 || ya !== '0 || fda !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got win=%h v=%b x=%0d y=%0d fd=%b expected all 0", wa, vouta, xa, ya, fda);
        end
        rst = 1'b0;
        @(negedge clk);
        set_cfg(2'd0, 28, 5, 1);
        drive_and_score(784, 100);
        checks++;
        if (win_cnt != 576 || fd_cnt != 1) begin
            failures++;
            $display("FAIL post_reset_count: got %0d windows %0d done expected 576 1", win_cnt, fd_cnt);
        end
    endtask

    task automatic test_small_stride3;
        set_cfg(2'd2, 8, 3, 3);
        drive_and_score(64, 100);
        checks++;
        if (win_cnt != 4 || fd_cnt != 1) begin
            failures++;
            $display("FAIL small_count: got %0d windows %0d done expected 4 1", win_cnt, fd_cnt);
        end
        checks++;
        if (xc !== 3'd1 || yc !== 3'd1) begin
            failures++;
            $display("FAIL small_last: got (%0d,%0d) expected (1,1)", xc, yc);
        end
    endtask

    initial begin
        test_reset;
        test_ramp_stride1;
        test_ramp_stride2;
        test_random_valid;
        test_back_to_back;
        test_reset_mid_frame;
        test_small_stride3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_buf.md
Name: conv_window_buf

Overview:
- Parametrised sliding-window line buffer for the CNN convolution layers.
- Accepts a raster-order pixel stream with a valid qualifier and emits one KxK window per valid output position, with configurable stride.
- Sits between the input stream (or the previous pool layer) and the convN_calc MAC arrays.
- Generalises the fixed 28x28/5x5 conv1 buffer to arbitrary image size, kernel and stride; tolerates input gaps and back-to-back frames.

Parameters:
- WIDTH, 28, image columns (>= K)
- HEIGHT, 28, image rows (>= K)
- DATA_BITS, 8, pixel width
- K, 5, square kernel size (2..7)
- STRIDE, 1, window step in x and y (1..K)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- valid_in  in  1  data_in is a valid pixel this cycle
- data_in  in  DATA_BITS  pixel, raster order
- window_out  out  K*K*DATA_BITS  flattened window; element (r,c) at [(r*K+c)*DATA_BITS +: DATA_BITS]; r=0 oldest row, c=0 leftmost column
- valid_out  out  1  window_out valid, one-cycle qualifier
- out_x  out  $clog2(WIDTH)  output-map column of the current window
- out_y  out  $clog2(HEIGHT)  output-map row of the current window
- frame_done  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset: all outputs and counters are 0. Window registers and line memories are cleared to 0. Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- Counters: in_x (0..WIDTH-1) and in_y (0..HEIGHT-1) advance only on valid_in. in_x wraps to 0 and increments in_y. in_y wraps to 0 after (WIDTH-1,HEIGHT-1). The next frame starts on the next accepted pixel, with no idle cycle required.
- Storage: K-1 row FIFOs of depth WIDTH, cascaded. The KxK window shift register shifts left by one column per accepted pixel. Column K-1 is loaded from {oldest FIFO tap ... newest tap, data_in}. Rows are held in fixed order; no rotation muxing.
- Emit condition on pixel (x,y): x >= K-1, y >= K-1, (x-(K-1)) % STRIDE == 0 and (y-(K-1)) % STRIDE == 0.
  - The window then covers rows y-K+1..y and columns x-K+1..x.
  - out_x = (x-(K-1))/STRIDE and out_y = (y-(K-1))/STRIDE. Maintain these with stride counters, not dividers.
- Latency: window_out, valid_out, out_x, out_y and frame_done are registered and appear exactly 1 cycle after the accepted pixel.
- valid_in low: no state advances and valid_out is 0 next cycle. window_out holds its last value.
- Windows never span a row wrap: positions with x < K-1 never assert valid_out.
- Outputs per frame: ((WIDTH-K)/STRIDE+1) * ((HEIGHT-K)/STRIDE+1), integer division.
- frame_done asserts with the window whose out_x and out_y are both maximal. It does not assert on a frame with no emitted window.
- No backpressure: the consumer must accept every valid_out.

Optional Feature:
- Macro: CONV_WINDOW_BUF_BORDER_EN.
- Defined: adds output sof (1 bit), asserted with out_x==0 && out_y==0, and output eol (1 bit), asserted with out_x maximal. Both have the same timing as valid_out and are 0 when valid_out is 0.
- Undefined: neither port exists and no associated logic is generated.

Decomposition:
- cnn_pkg holds:
  - clog2-derived width constants
  - the default DATA_BITS
  - the window element-index helper function (r*K+c)
- Sub-module conv_line_fifo:
  - single-clock delay line of depth WIDTH and width DATA_BITS
  - shift enabled by valid_in
  - instantiated K-1 times

Test Plan:
- Ramp, W=H=28, K=5, STRIDE=1, data=(y*28+x)&8'hFF, continuous valid_in:
  - first valid_out 1 cycle after pixel (4,4)
  - element (0,0)=0 and (4,4)=116
  - exactly 576 windows; frame_done with out_x=out_y=23
- Same ramp, STRIDE=2: 144 windows. Window (1,0) has element (0,0)=2. Last window is out_x=out_y=11.
- Random valid_in duty 50%: windows identical in value and order to the continuous run; valid_out never asserts in a cycle after valid_in is low.
- Two frames back-to-back: second frame windows match the first; frame_done exactly twice; no window mixes rows across frames.
- Assert rst after 300 pixels, then feed a fresh frame: all outputs 0 during reset; the fresh frame produces 576 correct windows.
- W=H=8, K=3, STRIDE=3: 4 windows at (0,0), (1,0), (0,1), (1,1). With CONV_WINDOW_BUF_BORDER_EN defined: sof on the first window, eol on the 2nd and 4th.
